// File: rtl/exu_operand_sched_pkg.sv
// Shared types and default widths for the EXU operand-collection scheduler.
package exu_operand_sched_pkg;

  localparam int unsigned XLEN_DEF   = 64;
  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ISSUE   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/exu_operand_sched_operand_slot.sv
// One source-operand collector: done flag, captured value and resolve priority.
module operand_slot
  import exu_operand_sched_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            eval,
  input  logic            use_src,
  input  logic            hazard,
  input  logic            fwd_valid,
  input  logic [XLEN-1:0] fwd_data,
  input  logic [XLEN-1:0] rf_data,
  output logic            resolved,
  output logic [XLEN-1:0] value
);

  logic            done;
  logic            hit;
  logic [XLEN-1:0] pick;

  always_comb begin
    hit  = 1'b0;
    pick = '0;
    if (!use_src) begin
      hit = 1'b1;
    end else if (!hazard) begin
      hit  = 1'b1;
      pick = rf_data;
    end else if (fwd_valid) begin
      hit  = 1'b1;
      pick = fwd_data;
    end
  end

  // Includes an operand resolving this cycle so the scheduler can leave COLLECT immediately.
  assign resolved = done || (eval && hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done  <= 1'b0;
      value <= '0;
    end else if (clear) begin
      done <= 1'b0;
    end else if (eval && !done && hit) begin
      done  <= 1'b1;
      value <= pick;
    end
  end

endmodule

// File: rtl/exu_operand_sched.sv
// Operand-collection scheduler between the IDU/EXU pipeline register and the EXU.
module exu_operand_sched
  import exu_operand_sched_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  output logic [REG_AW-1:0] exu_rs1,
  output logic [REG_AW-1:0] exu_rs2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              hazard_rs1,
  input  logic              hazard_rs2,
  input  logic              forward_rs1_valid,
  input  logic              forward_rs2_valid,
  input  logic [XLEN-1:0]   forward_R_rs1,
  input  logic [XLEN-1:0]   forward_R_rs2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_src1,
  output logic [XLEN-1:0]   out_src2,
  output logic [CNT_W-1:0]  stall_cycles
);

  sched_state_e state_q, state_d;
  logic use1_q, use2_q;
  logic accept, eval, clear;
  logic res1, res2;

  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_IDLE:  in_ready = 1'b1;
        ST_ISSUE: in_ready = out_ready;
        default:  in_ready = 1'b0;
      endcase
    end
  end

  assign accept    = in_valid && in_ready;
  assign eval      = (state_q == ST_COLLECT) && !flush;
  assign clear     = flush || accept;
  assign out_valid = (state_q == ST_ISSUE);

  operand_slot #(.XLEN(XLEN)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .eval      (eval),
    .use_src   (use1_q),
    .hazard    (hazard_rs1),
    .fwd_valid (forward_rs1_valid),
    .fwd_data  (forward_R_rs1),
    .rf_data   (rf_rdata1),
    .resolved  (res1),
    .value     (out_src1)
  );

  operand_slot #(.XLEN(XLEN)) u_slot2 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .eval      (eval),
    .use_src   (use2_q),
    .hazard    (hazard_rs2),
    .fwd_valid (forward_rs2_valid),
    .fwd_data  (forward_R_rs2),
    .rf_data   (rf_rdata2),
    .resolved  (res2),
    .value     (out_src2)
  );

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (accept) state_d = ST_COLLECT;
        ST_COLLECT: if (res1 && res2) state_d = ST_ISSUE;
        ST_ISSUE:   if (out_ready) state_d = accept ? ST_COLLECT : ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      exu_rs1 <= '0;
      exu_rs2 <= '0;
      use1_q  <= 1'b0;
      use2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        exu_rs1 <= in_rs1;
        exu_rs2 <= in_rs2;
        use1_q  <= in_use_rs1;
        use2_q  <= in_use_rs2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (eval && !(res1 && res2) && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exu_operand_sched.sv
// Randomized scoreboard bench for exu_operand_sched with a transaction-level reference model.
module tb_exu_operand_sched;
  import exu_operand_sched_pkg::*;

  localparam int unsigned XL = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic [AW-1:0] in_rs1, in_rs2, exu_rs1, exu_rs2;
  logic          in_use_rs1, in_use_rs2;
  logic [XL-1:0] rf_rdata1, rf_rdata2, forward_R_rs1, forward_R_rs2, out_src1, out_src2;
  logic          hazard_rs1, hazard_rs2, forward_rs1_valid, forward_rs2_valid;
  logic          out_valid, out_ready;
  logic [CW-1:0] stall_cycles;
  logic          h1_raw, h2_raw;
  logic [XL-1:0] rf [32];

  always #5 clk = ~clk;

  // Environment: combinational regfile read and a forwarding unit that never flags x0.
  assign rf_rdata1  = (exu_rs1 == '0) ? '0 : rf[exu_rs1];
  assign rf_rdata2  = (exu_rs2 == '0) ? '0 : rf[exu_rs2];
  assign hazard_rs1 = h1_raw && (exu_rs1 != '0);
  assign hazard_rs2 = h2_raw && (exu_rs2 != '0);

  exu_operand_sched #(.XLEN(XL), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .exu_rs1(exu_rs1), .exu_rs2(exu_rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
    .forward_rs1_valid(forward_rs1_valid), .forward_rs2_valid(forward_rs2_valid),
    .forward_R_rs1(forward_R_rs1), .forward_R_rs2(forward_R_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_src1(out_src1), .out_src2(out_src2),
    .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic [XL-1:0] s1, s2;
    logic [AW-1:0] r1, r2;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: one held instruction, each operand captured once, then handed off.
  logic          m_busy, m_issue, m_d1, m_d2, m_u1, m_u2;
  logic [XL-1:0] m_v1, m_v2;
  logic [AW-1:0] m_r1, m_r2;
  int unsigned   m_stall;

  function automatic logic try_resolve(input logic u, input logic h, input logic fv,
                                       input logic [AW-1:0] r, input logic [XL-1:0] fd,
                                       output logic [XL-1:0] v);
    v = '0;
    if (!u) return 1'b1;
    if (!h || r == '0) begin
      v = (r == '0) ? '0 : rf[r];
      return 1'b1;
    end
    if (fv) begin
      v = fd;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_issue = 0; m_d1 = 0; m_d2 = 0; m_stall = 0;
    exp_q.delete();
  endtask

  task automatic step(input logic iv, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic u1, input logic u2, input logic h1, input logic h2,
                      input logic fv1, input logic fv2, input logic [XL-1:0] fd1,
                      input logic [XL-1:0] fd2, input logic fl, input logic ordy, input logic wb);
    logic          exp_ready, ok;
    logic [XL-1:0] v;
    @(negedge clk);
    in_valid = iv; in_rs1 = r1; in_rs2 = r2; in_use_rs1 = u1; in_use_rs2 = u2;
    h1_raw = h1; h2_raw = h2; forward_rs1_valid = fv1; forward_rs2_valid = fv2;
    forward_R_rs1 = fd1; forward_R_rs2 = fd2; flush = fl; out_ready = ordy;
    if (wb) rf[$urandom_range(1, 31)] = {$urandom, $urandom};
    #1;
    exp_ready = !fl && (!m_busy || (m_issue && ordy));
    chk("in_ready", XL'(in_ready), XL'(exp_ready));
    chk("out_valid", XL'(out_valid), XL'(m_issue));
    chk("stall_cycles", XL'(stall_cycles), XL'(m_stall));
    if (fl) begin
      m_busy = 0; m_issue = 0;
    end else begin
      if (m_busy && !m_issue) begin
        if (!m_d1) begin ok = try_resolve(m_u1, h1, fv1, m_r1, fd1, v); if (ok) begin m_d1 = 1; m_v1 = v; end end
        if (!m_d2) begin ok = try_resolve(m_u2, h2, fv2, m_r2, fd2, v); if (ok) begin m_d2 = 1; m_v2 = v; end end
        if (m_d1 && m_d2) begin
          m_issue = 1;
          exp_q.push_back('{s1: m_v1, s2: m_v2, r1: m_r1, r2: m_r2});
        end else if (m_stall < (1 << CW) - 1) begin
          m_stall++;
        end
      end else if (m_issue && ordy) begin
        m_busy = 0; m_issue = 0;
      end
      if (exp_ready && iv) begin
        m_busy = 1; m_issue = 0; m_d1 = 0; m_d2 = 0;
        m_r1 = r1; m_r2 = r2; m_u1 = u1; m_u2 = u2;
      end
    end
  endtask

  // Monitor: whatever the EXU sees while out_valid must match the oldest expected operand set.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_issue actual=out_valid required=no_pending t=%0t", $time);
        end else begin
          chk("out_src1", out_src1, exp_q[0].s1);
          chk("out_src2", out_src2, exp_q[0].s2);
          chk("exu_rs1", XL'(exu_rs1), XL'(exp_q[0].r1));
          chk("exu_rs2", XL'(exu_rs2), XL'(exp_q[0].r2));
          if (out_ready || flush) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 0; flush = 0; out_ready = 0; in_rs1 = '0; in_rs2 = '0;
    in_use_rs1 = 0; in_use_rs2 = 0; h1_raw = 0; h2_raw = 0;
    forward_rs1_valid = 0; forward_rs2_valid = 0; forward_R_rs1 = '0; forward_R_rs2 = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, XL'(in_ready), XL'(1));
    chk({tag, "_out_valid"}, XL'(out_valid), '0);
    chk({tag, "_out_src1"}, out_src1, '0);
    chk({tag, "_out_src2"}, out_src2, '0);
    chk({tag, "_exu_rs1"}, XL'(exu_rs1), '0);
    chk({tag, "_stall"}, XL'(stall_cycles), '0);
  endtask

  localparam logic [XL-1:0] DEAD = 64'hDEAD;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    rf[0] = '0; rf[5] = 64'h11; rf[6] = 64'h22;
    idle_inputs();
    rst = 1;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst = 0;

    // No hazards: accept, one COLLECT cycle, then ISSUE.
    step(1, 5, 6, 1, 1, 0, 0, 0, 0, '0, '0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, '0, '0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, '0, '0, 0, 1, 0);

    // rs1 hazard waiting three cycles for the forward.
    step(1, 7, 6, 1, 1, 0, 0, 0, 0, '0, '0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, 0, 0, 0, '0, '0, 0, 0, 1);
    step(0, 0, 0, 1, 1, 1, 0, 1, 0, DEAD, '0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, '0, '0, 0, 1, 0);

    // Both hazarded; rs2 captured first, later forward_R_rs2 changes must not leak in.
    step(1, 3, 4, 1, 1, 0, 0, 0, 0, '0, '0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 1, 0, 1, 64'h1, 64'hBEEF, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 1, 0, 1, 64'h2, 64'h5555, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 1, 0, 0, 64'h3, 64'h6666, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 1, 1, 1, 64'hC0DE, 64'h7777, 0, 0, 0);
    // ISSUE held four cycles, then handoff with back-to-back accept.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0, 0, 0, 0, '0, '0, 0, 0, 1);
    step(1, 9, 0, 1, 1, 0, 1, 0, 0, '0, '0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, '0, '0, 0, 0, 0);

    // Flush in ISSUE and in COLLECT with in_valid high, then a normal accept.
    step(1, 8, 8, 1, 1, 0, 0, 0, 0, '0, '0, 1, 0, 0);
    step(1, 8, 8, 1, 1, 0, 0, 0, 0, '0, '0, 0, 0, 0);
    step(1, 8, 8, 1, 1, 1, 1, 0, 0, '0, '0, 1, 0, 0);
    step(1, 10, 11, 1, 0, 0, 1, 0, 0, '0, '0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 1, 0, 0, '0, '0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, '0, '0, 0, 1, 0);

    // Async reset in the middle of COLLECT.
    step(1, 12, 13, 1, 1, 0, 0, 0, 0, '0, '0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0, 0, 0, '0, '0, 0, 0, 0);
    #2;
    idle_inputs();
    rst = 1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk); rst = 0;

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, AW'($urandom), AW'($urandom),
           $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0, 0, 1, 0);
    #3;
    chk("drain_empty", XL'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exu_operand_sched.md
Name: exu_operand_sched

Overview:
Operand-collection scheduler between the IDU→EXU pipeline register and the EXU. It accepts one instruction at a time and drives that instruction's source indices to the forwarding unit and the register file. Each source operand is captured from either the forwarded data or the register file. The block stalls until both operands are resolved, then presents them to the EXU with a valid/ready handshake. It also counts operand-stall cycles for performance analysis.

Parameters:
XLEN, 64, operand data width
REG_AW, 5, register index width
CNT_W, 32, stall counter width (saturating)

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
flush  input  1  synchronous pipeline flush (redirect); discards held instruction
in_valid  input  1  IDU offers instruction
in_ready  output  1  block can accept an instruction this cycle
in_rs1  input  REG_AW  source 1 index
in_rs2  input  REG_AW  source 2 index
in_use_rs1  input  1  instruction reads rs1
in_use_rs2  input  1  instruction reads rs2
exu_rs1  output  REG_AW  held rs1 index, to forwarding unit and regfile read port 1
exu_rs2  output  REG_AW  held rs2 index, to forwarding unit and regfile read port 2
rf_rdata1  input  XLEN  regfile read data for exu_rs1 (combinational)
rf_rdata2  input  XLEN  regfile read data for exu_rs2 (combinational)
hazard_rs1  input  1  forwarding unit: rs1 matches an in-flight writer
hazard_rs2  input  1  forwarding unit: rs2 matches an in-flight writer
forward_rs1_valid  input  1  forwarded rs1 data is available
forward_rs2_valid  input  1  forwarded rs2 data is available
forward_R_rs1  input  XLEN  forwarded rs1 data
forward_R_rs2  input  XLEN  forwarded rs2 data
out_valid  output  1  operands resolved, instruction presented to EXU
out_ready  input  1  EXU accepts
out_src1  output  XLEN  resolved operand 1
out_src2  output  XLEN  resolved operand 2
stall_cycles  output  CNT_W  count of COLLECT cycles with at least one unresolved operand

Behaviour:
- Reset values: state=IDLE; out_valid=0; out_src1/out_src2=0; exu_rs1/exu_rs2=0; done flags=0; stall_cycles=0.
- States:
  - IDLE: in_ready=1. On in_valid, latch rs1/rs2/use bits, clear done1/done2, go to COLLECT.
  - COLLECT: in_ready=0. Resolve each operand independently each cycle while its done flag is 0:
    - !use → done, value 0.
    - use && !hazard → done, value rf_rdata.
    - use && hazard && forward_valid → done, value forward_R.
    - use && hazard && !forward_valid → wait.
  - Once both done flags are set (including flags set in the current cycle), go to ISSUE the next cycle.
  - ISSUE: out_valid=1; out_src1/out_src2 and indices held stable until out_ready.
    - in_ready = out_ready.
    - On out_ready && in_valid: accept the new instruction and go to COLLECT (back-to-back, no bubble).
    - On out_ready && !in_valid: go to IDLE.
- Latency: accept at cycle N → operands resolved at N+1 at the earliest → out_valid at N+2.
- Register values are not latched at accept. The regfile is re-read every COLLECT cycle so that writebacks retiring during the stall are observed.
- A captured operand is never overwritten until the next accept.
- rs=0 reads as 0 through the regfile; the forwarding unit reports no hazard for rs=0.
- flush has priority over every event. Next cycle: state=IDLE, out_valid=0, done flags cleared. in_valid in the flush cycle is ignored: in_ready is forced to 0 while flush=1.
- Async rst mid-operation returns all state to reset values immediately.
- stall_cycles increments in each COLLECT cycle where either operand remains unresolved after evaluation. It saturates at all-ones and is cleared only by rst.
- ISSUE with out_ready=0 holds all outputs stable indefinitely.

Decomposition:
- Shared package: state enum encoding (IDLE=2'd0, COLLECT=2'd1, ISSUE=2'd2), XLEN/REG_AW constants.
- One sub-module, operand_slot, instantiated twice. It holds the done flag and value register and implements the resolve priority (use / hazard / forward_valid / rf), keeping the per-operand logic identical.

Test Plan:
- No hazards: accept rs1=5, rs2=6 with rf_rdata=0x11/0x22 at cycle 0 → out_valid at cycle 2, out_src1=0x11, out_src2=0x22; stall_cycles=0.
- rs1 hazard, forward_rs1_valid low for 3 cycles then high with forward_R_rs1=0xDEAD → out_valid 1 cycle after the forward goes valid, out_src1=0xDEAD; stall_cycles=3.
- Hazard on both, rs2 forward valid at COLLECT cycle 1 and rs1 at cycle 4 → rs2 value kept from cycle 1 despite later changes on forward_R_rs2; out_valid at cycle 5 after accept.
- ISSUE with out_ready=0 for 4 cycles, then out_ready=1 with in_valid=1 → outputs stable during the hold; the new instruction is accepted in the same cycle as the handoff; COLLECT follows the next cycle.
- flush asserted in COLLECT and again in ISSUE, each with in_valid=1 → in_ready=0 in the flush cycle; next cycle state IDLE, out_valid=0; the following in_valid is accepted normally.
- in_use_rs2=0 with hazard_rs2=1 → rs2 resolves immediately with value 0; no stall from rs2. Async rst pulse during COLLECT → outputs return to 0 and in_ready=1 at once.
